miner_controller: RTL and testbench

// Top-level sequencing FSM of the miner core. Drives the 3-bit controller_state
// bus that the shift timer decodes. Consumes the timer's midstate/remaining

---
 rtl/miner_controller.sv | 160 ++++++++++++++++
 tb/tb_miner_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/miner_controller.sv
// miner_controller: top-level sequencing FSM of the miner core.
// Drives the encoded controller_state bus decoded by the shift timer, launches
// one hash per nonce, steps the nonce and reports a golden nonce or exhaustion.
// Optional HASH watchdog: define MINER_CTRL_TIMEOUT_EN to build it.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE   000 | waiting for start; shift timer held in reset
// LOAD_MID 001 | shifting midstate into the header register
// LOAD_REM 010 | shifting remaining block; timer keeps counting from LOAD_MID
// HASH   011 | hash of current nonce in flight; first cycle pulses hash_start
// CHECK  100 | evaluate latched hit and end-of-range
// NEXT   101 | step nonce, relaunch hash without reloading the header
// FOUND  110 | golden nonce held on nonce
// EXHAUSTED 111 | range done without a hit
module miner_controller #(
  parameter int unsigned         NONCE_W        = 32,
  parameter logic [NONCE_W-1:0]  NONCE_START    = '0,
  parameter logic [NONCE_W-1:0]  NONCE_LAST     = '1,
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic               midstate_shifts_done,
  input  logic               remaining_shifts_done,
  input  logic               hash_done,
  input  logic               hash_hit,
  output logic [2:0]         controller_state,
  output logic               shift_enable,
  output logic               hash_start,
  output logic [NONCE_W-1:0] nonce,
  output logic               found,
  output logic               exhausted,
  output logic               timeout_err
);

  // Encoding is fixed: the shift timer decodes these values directly.
  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_LOAD_MID  = 3'b001,
    S_LOAD_REM  = 3'b010,
    S_HASH      = 3'b011,
    S_CHECK     = 3'b100,
    S_NEXT      = 3'b101,
    S_FOUND     = 3'b110,
    S_EXHAUSTED = 3'b111
  } state_t;

  state_t               state_q, state_d;
  logic [NONCE_W-1:0]   nonce_d;
  logic                 hit_q, hit_d;
  logic                 hash_start_d;
  logic                 timeout_err_d;
  logic                 wd_expired;

`ifdef MINER_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Watchdog down-counter: reloads on HASH entry, terminal count = timeout.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_q <= '0;
    end else if (hash_start_d) begin
      wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == S_HASH && wd_q != '0) begin
      wd_q <= wd_q - WD_W'(1);
    end
  end

  assign wd_expired = (state_q == S_HASH) && (wd_q == '0);
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state and next-output decode; abort overrides every transition.
  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce;
    hit_d         = hit_q;
    hash_start_d  = 1'b0;
    timeout_err_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD_MID;
            nonce_d = NONCE_START;
          end
        end
        S_LOAD_MID: begin
          if (midstate_shifts_done) state_d = S_LOAD_REM;
        end
        S_LOAD_REM: begin
          if (remaining_shifts_done) begin
            state_d      = S_HASH;
            hash_start_d = 1'b1;
          end
        end
        S_HASH: begin
          // hash_start is high only in the first HASH cycle; a result there
          // cannot belong to the hash just launched.
          if (!hash_start && hash_done) begin
            state_d = S_CHECK;
            hit_d   = hash_hit;
          end else if (wd_expired) begin
            state_d       = S_CHECK;
            hit_d         = 1'b0;
            timeout_err_d = 1'b1;
          end
        end
        S_CHECK: begin
          if (hit_q)                    state_d = S_FOUND;
          else if (nonce == NONCE_LAST) state_d = S_EXHAUSTED;
          else                          state_d = S_NEXT;
        end
        S_NEXT: begin
          nonce_d      = nonce + NONCE_W'(1);
          state_d      = S_HASH;
          hash_start_d = 1'b1;
        end
        S_FOUND, S_EXHAUSTED: begin
          // Always pass through IDLE so the timer sees a reset cycle.
          if (start) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, nonce and registered Moore outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      nonce        <= NONCE_START;
      hit_q        <= 1'b0;
      hash_start   <= 1'b0;
      shift_enable <= 1'b0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      nonce        <= nonce_d;
      hit_q        <= hit_d;
      hash_start   <= hash_start_d;
      shift_enable <= (state_d == S_LOAD_MID) || (state_d == S_LOAD_REM);
      found        <= (state_d == S_FOUND);
      exhausted    <= (state_d == S_EXHAUSTED);
      timeout_err  <= timeout_err_d;
    end
  end

  assign controller_state = state_q;

endmodule

// File: tb/tb_miner_controller.sv
// tb_miner_controller: directed/randomized bench for miner_controller with a
// behavioural shift timer and hash pipeline responder.
module tb_miner_controller;
  localparam int W  = 8;
  localparam int TO = 16;

  localparam logic [2:0] S_IDLE = 3'b000, S_MID = 3'b001, S_REM = 3'b010,
                         S_HASH = 3'b011, S_CHECK = 3'b100, S_NEXT = 3'b101,
                         S_FOUND = 3'b110, S_EXH = 3'b111;

  logic         clk = 1'b0;
  logic         n_rst, start, abort, hash_done, hash_hit;
  logic         mid_done, rem_done;
  logic [2:0]   cs;
  logic         shift_enable, hash_start, found, exhausted, timeout_err;
  logic [W-1:0] nonce;
  logic [4:0]   tcnt;
  int           total = 0;
  int           bad = 0;
  int           hs_seen = 0;
  int           te_count = 0;

  miner_controller #(
    .NONCE_W(W), .NONCE_START(8'h00), .NONCE_LAST(8'hFF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .midstate_shifts_done(mid_done), .remaining_shifts_done(rem_done),
    .hash_done(hash_done), .hash_hit(hash_hit),
    .controller_state(cs), .shift_enable(shift_enable), .hash_start(hash_start),
    .nonce(nonce), .found(found), .exhausted(exhausted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Shift timer: reset in IDLE, counts up and parks at 24.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)              tcnt <= '0;
    else if (cs == S_IDLE)   tcnt <= '0;
    else if (tcnt < 5'd24)   tcnt <= tcnt + 5'd1;
  end
  assign mid_done = (tcnt >= 5'd8);
  assign rem_done = (tcnt >= 5'd24);

  always @(negedge clk) if (timeout_err === 1'b1) te_count <= te_count + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From IDLE: start a job and measure the header load; ends in first HASH cycle.
  task automatic do_load();
    int n_mid = 0, n_rem = 0, n_se = 0, g = 0;
    start = 1'b1; tick();
    while (cs == S_MID && g < 100) begin
      n_mid++; if (shift_enable) n_se++;
      start = 1'($urandom_range(0, 1)); tick(); g++;
    end
    while (cs == S_REM && g < 100) begin
      n_rem++; if (shift_enable) n_se++;
      start = 1'($urandom_range(0, 1)); tick(); g++;
    end
    start = 1'b0;
    chk("load_mid_cycles", n_mid, 9);
    chk("load_rem_cycles", n_rem, 16);
    chk("shift_en_cycles", n_se, 25);
    chk("load_to_hash", cs, S_HASH);
    chk("load_hash_start", hash_start, 1);
    chk("load_nonce_start", nonce, 0);
  endtask

  // From first HASH cycle: answer after lat extra cycles; ends in CHECK.
  task automatic hash_phase(input bit hit, input int lat);
    if (hash_start) hs_seen++;
    hash_done = 1'($urandom_range(0, 1)); hash_hit = 1'b1;
    tick();
    chk("hash_ignore_first", cs, S_HASH);
    for (int i = 0; i < lat; i++) begin
      if (hash_start) hs_seen++;
      hash_done = 1'b0; hash_hit = 1'($urandom_range(0, 1));
      tick();
      chk("hash_wait", cs, S_HASH);
    end
    if (hash_start) hs_seen++;
    hash_done = 1'b1; hash_hit = hit;
    tick();
    hash_done = 1'b0; hash_hit = 1'b0;
    chk("hash_to_check", cs, S_CHECK);
    if (hash_start) hs_seen++;
  endtask

  // Reference: nonces START.. tried in order; stop at hit_at or at 0xFF.
  task automatic search(input int hit_at);
    int exp_n = 0;
    bit done = 1'b0;
    int g = 0;
    while (!done && g < 300) begin
      g++;
      chk("try_nonce", nonce, exp_n);
      chk("try_hash_start", hash_start, 1);
      hash_phase(exp_n == hit_at, $urandom_range(0, 5));
      tick();
      if (exp_n == hit_at) begin
        chk("found_state", cs, S_FOUND);
        chk("found_flag", found, 1);
        chk("golden_nonce", nonce, exp_n);
        done = 1'b1;
      end else if (exp_n == 255) begin
        chk("exh_state", cs, S_EXH);
        chk("exh_flag", exhausted, 1);
        chk("exh_nonce", nonce, 8'hFF);
        done = 1'b1;
      end else begin
        chk("next_state", cs, S_NEXT);
        chk("next_nonce_hold", nonce, exp_n);
        tick();
        exp_n++;
      end
    end
    chk("search_ended", done, 1);
  endtask

  initial begin
    int g, n;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; hash_done = 1'b0; hash_hit = 1'b0;
    repeat (3) tick();
    chk("rst_state", cs, S_IDLE);
    chk("rst_nonce", nonce, 0);
    chk("rst_shift_en", shift_enable, 0);
    chk("rst_hash_start", hash_start, 0);
    chk("rst_found", found, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_timeout", timeout_err, 0);
    n_rst = 1'b1; tick(); tick();
    chk("idle_hold", cs, S_IDLE);

    // Full job, hit on nonce 2
    hs_seen = 0;
    do_load();
    search(2);
    chk("hash_start_count", hs_seen, 3);
    repeat ($urandom_range(2, 6)) begin
      hash_done = 1'($urandom_range(0, 1)); hash_hit = 1'($urandom_range(0, 1));
      tick();
      chk("found_held", cs, S_FOUND);
      chk("golden_held", nonce, 2);
    end
    hash_done = 1'b0; hash_hit = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("found_to_idle", cs, S_IDLE);
    chk("found_cleared", found, 0);
    chk("idle_nonce_kept", nonce, 2);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("idle_abort_start", cs, S_IDLE);
    chk("idle_abort_nonce", nonce, 2);

    // abort + start in a later HASH cycle
    do_load();
    tick();
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("hash_abort_state", cs, S_IDLE);
    chk("hash_abort_no_start", hash_start, 0);
    chk("hash_abort_nonce", nonce, 0);

    // abort in NEXT must not step the nonce
    do_load();
    hash_phase(1'b0, 2);
    tick();
    chk("pre_abort_next", cs, S_NEXT);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("next_abort_state", cs, S_IDLE);
    chk("next_abort_nonce", nonce, 0);

    // Exhaustion: every nonce misses, no wrap past 0xFF
    do_load();
    search(-1);
    repeat (3) begin
      tick();
      chk("exh_held", exhausted, 1);
      chk("exh_no_wrap", nonce, 8'hFF);
    end
    start = 1'b1; tick(); start = 1'b0;
    chk("exh_to_idle", cs, S_IDLE);

    // Async reset in the middle of LOAD_REM
    start = 1'b1; tick(); start = 1'b0;
    g = 0;
    while (cs != S_REM && g < 50) begin tick(); g++; end
    chk("reach_rem", cs, S_REM);
    tick(); tick(); tick();
    #3 n_rst = 1'b0;
    #1;
    chk("arst_state", cs, S_IDLE);
    chk("arst_shift_en", shift_enable, 0);
    chk("arst_nonce", nonce, 0);
    #2 n_rst = 1'b1;
    tick();
    do_load();

    // HASH with no hash_done
    n = 0;
    while (cs == S_HASH && n < 60) begin n++; tick(); end
`ifdef MINER_CTRL_TIMEOUT_EN
    chk("wd_hash_cycles", n, TO);
    chk("wd_to_check", cs, S_CHECK);
    chk("wd_pulse", timeout_err, 1);
    tick();
    chk("wd_next", cs, S_NEXT);
    chk("wd_pulse_end", timeout_err, 0);
    tick();
    chk("wd_rehash", cs, S_HASH);
    chk("wd_nonce_inc", nonce, 1);
    chk("wd_new_start", hash_start, 1);
    hash_phase(1'b1, TO - 2);
    chk("wd_done_wins_err", timeout_err, 0);
    tick();
    chk("wd_done_wins_found", cs, S_FOUND);
    chk("wd_pulse_total", te_count, 1);
    start = 1'b1; tick(); start = 1'b0;
`else
    chk("no_wd_wait", n, 60);
    chk("no_wd_state", cs, S_HASH);
    chk("no_wd_pulses", te_count, 0);
    abort = 1'b1; tick(); abort = 1'b0;
`endif
    chk("final_idle", cs, S_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
